// File: rtl/scene_host.sv
// Scene-state owner: player view plus object table, edited in a pending copy
// and committed to the live copy the renderer reads on frame_sync.
module scene_host #(
    parameter  int NUM_OBJ    = 4,
    parameter  int X_W        = 10,
    parameter  int Y_W        = 10,
    parameter  int Z_W        = 8,
    parameter  int STEP_SHIFT = 2,
    parameter  int REPEAT     = 1024,
    localparam int OBJ_W      = 14 + 2*X_W + 2*Y_W + 2*Z_W,
    localparam int IDX_W      = $clog2(NUM_OBJ),
    localparam int VIEW_W     = X_W + Y_W + Z_W + 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               rotate,
    input  logic [1:0]               move,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [OBJ_W-1:0]         wr_data,
    input  logic                     frame_sync,
    output logic [VIEW_W-1:0]        out_view,
    output logic [NUM_OBJ*OBJ_W-1:0] out_objs,
    output logic                     wr_err
);
    localparam int CNT_W = $clog2(REPEAT + 1);
    localparam int X_MAX = (1 << X_W) - 1;
    localparam int Y_MAX = (1 << Y_W) - 1;
    localparam logic [VIEW_W-1:0] VIEW_RST =
        {4'd0, 11'd0, 11'd16, {X_W{1'b0}}, {Y_W{1'b0}}, {Z_W{1'b0}}};

    // 16*sin(h*22.5 deg), rounded; cos is the same table shifted by 4.
    function automatic logic signed [10:0] sin16(input logic [3:0] h);
        case (h)
            4'd0:  sin16 = 11'sd0;    4'd1:  sin16 = 11'sd6;
            4'd2:  sin16 = 11'sd11;   4'd3:  sin16 = 11'sd15;
            4'd4:  sin16 = 11'sd16;   4'd5:  sin16 = 11'sd15;
            4'd6:  sin16 = 11'sd11;   4'd7:  sin16 = 11'sd6;
            4'd8:  sin16 = 11'sd0;    4'd9:  sin16 = -11'sd6;
            4'd10: sin16 = -11'sd11;  4'd11: sin16 = -11'sd15;
            4'd12: sin16 = -11'sd16;  4'd13: sin16 = -11'sd15;
            4'd14: sin16 = -11'sd11;  default: sin16 = -11'sd6;
        endcase
    endfunction

    function automatic logic [OBJ_W-1:0] reset_slot(input int i);
        if (i == 0)
            reset_slot = {1'b1, 1'b0, 12'hFFF, X_W'(0), X_W'(16), Y_W'(32), Y_W'(0),
                          Z_W'(16), Z_W'(0)};
        else if (i == 1)
            reset_slot = {1'b1, 1'b1, 12'hFFF, X_W'(16), X_W'(32), Y_W'(20), Y_W'(36),
                          Z_W'(0), Z_W'(30)};
        else
            reset_slot = '0;
    endfunction

    function automatic logic [X_W-1:0] sat_x(input logic signed [31:0] v);
        if (v < 0)          sat_x = '0;
        else if (v > X_MAX) sat_x = '1;
        else                sat_x = v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] sat_y(input logic signed [31:0] v);
        if (v < 0)          sat_y = '0;
        else if (v > Y_MAX) sat_y = '1;
        else                sat_y = v[Y_W-1:0];
    endfunction

    logic [1:0]               rot_prev_q, mv_prev_q;
    logic [CNT_W-1:0]         rot_cnt_q, rot_cnt_d, mv_cnt_q, mv_cnt_d;
    logic [3:0]               h_q, h_d;
    logic [X_W-1:0]           x_q, x_d;
    logic [Y_W-1:0]           y_q, y_d;
    logic [Z_W-1:0]           z_q;
    logic [OBJ_W-1:0]         pend_q [NUM_OBJ];
    logic [NUM_OBJ*OBJ_W-1:0] live_objs_q;
    logic [VIEW_W-1:0]        live_view_q, pend_view;
    logic                     wr_err_q;

    logic                     rot_valid, rot_fire, mv_valid, mv_fire, wr_take, idx_ok;
    logic signed [10:0]       nx, ny;
    logic signed [31:0]       dx, dy, x_sum, y_sum;

    assign wr_ready = ~frame_sync;
    assign wr_take  = wr_valid & ~frame_sync;
    assign idx_ok   = (32'(wr_idx) < NUM_OBJ);

    // A code fires when newly seen, then every REPEAT cycles while held.
    always_comb begin
        rot_valid = (rotate == 2'b01) || (rotate == 2'b10);
        rot_fire  = rot_valid && ((rotate != rot_prev_q) || (rot_cnt_q == CNT_W'(REPEAT)));
        rot_cnt_d = !rot_valid ? '0 : (rot_fire ? CNT_W'(1) : rot_cnt_q + CNT_W'(1));
        mv_valid  = (move == 2'b01) || (move == 2'b10);
        mv_fire   = mv_valid && ((move != mv_prev_q) || (mv_cnt_q == CNT_W'(REPEAT)));
        mv_cnt_d  = !mv_valid ? '0 : (mv_fire ? CNT_W'(1) : mv_cnt_q + CNT_W'(1));
    end

    always_comb begin
        nx    = sin16(h_q);
        ny    = sin16(h_q + 4'd4);
        dx    = 32'(nx) >>> STEP_SHIFT;
        dy    = 32'(ny) >>> STEP_SHIFT;
        x_sum = $signed({{(32-X_W){1'b0}}, x_q}) + ((move == 2'b10) ? dx : -dx);
        y_sum = $signed({{(32-Y_W){1'b0}}, y_q}) + ((move == 2'b10) ? dy : -dy);
        x_d   = mv_fire ? sat_x(x_sum) : x_q;
        y_d   = mv_fire ? sat_y(y_sum) : y_q;
        h_d   = h_q;
        if (rot_fire) h_d = (rotate == 2'b01) ? h_q + 4'd1 : h_q - 4'd1;
        pend_view = {h_q, nx, ny, x_q, y_q, z_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot_prev_q  <= 2'b00;
            mv_prev_q   <= 2'b00;
            rot_cnt_q   <= '0;
            mv_cnt_q    <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            live_view_q <= VIEW_RST;
            wr_err_q    <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                pend_q[i]                     <= reset_slot(i);
                live_objs_q[i*OBJ_W +: OBJ_W] <= reset_slot(i);
            end
        end else begin
            rot_prev_q <= rotate;
            mv_prev_q  <= move;
            rot_cnt_q  <= rot_cnt_d;
            mv_cnt_q   <= mv_cnt_d;
            h_q        <= h_d;
            x_q        <= x_d;
            y_q        <= y_d;
            if (frame_sync) begin
                live_view_q <= pend_view;
                for (int i = 0; i < NUM_OBJ; i++)
                    live_objs_q[i*OBJ_W +: OBJ_W] <= pend_q[i];
            end
            if (wr_take) begin
                if (idx_ok) pend_q[wr_idx] <= wr_data;
                else        wr_err_q       <= 1'b1;
            end
        end
    end

    assign out_view = live_view_q;
    assign out_objs = live_objs_q;
    assign wr_err   = wr_err_q;
endmodule

// File: tb/tb_scene_host.sv
// Bench for scene_host: directed steps plus a randomized phase, all checked
// against a view/object model computed from trigonometry and hold counts.
module tb_scene_host;
  localparam int NUM_OBJ = 4;
  localparam int X_W = 10, Y_W = 10, Z_W = 8, STEP_SHIFT = 2, REPEAT = 1024;
  localparam int OBJ_W = 14 + 2*X_W + 2*Y_W + 2*Z_W;
  localparam int VIEW_W = X_W + Y_W + Z_W + 26;

  logic clk = 0, rst = 0;
  logic [1:0] rotate = 0, move = 0;
  logic wr_valid = 0, frame_sync = 0;
  logic [1:0] wr_idx = 0;
  logic [OBJ_W-1:0] wr_data = '0;
  logic wr_ready, wr_err, wr_ready3, wr_err3;
  logic [VIEW_W-1:0] out_view, out_view3;
  logic [NUM_OBJ*OBJ_W-1:0] out_objs;
  logic [3*OBJ_W-1:0] out_objs3;

  int checks = 0, errors = 0;

  scene_host #(.NUM_OBJ(4), .X_W(X_W), .Y_W(Y_W), .Z_W(Z_W), .STEP_SHIFT(STEP_SHIFT),
               .REPEAT(REPEAT)) dut (
    .clk(clk), .rst(rst), .rotate(rotate), .move(move), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data), .frame_sync(frame_sync),
    .out_view(out_view), .out_objs(out_objs), .wr_err(wr_err));

  scene_host #(.NUM_OBJ(3), .X_W(X_W), .Y_W(Y_W), .Z_W(Z_W), .STEP_SHIFT(STEP_SHIFT),
               .REPEAT(REPEAT)) dut3 (
    .clk(clk), .rst(rst), .rotate(rotate), .move(move), .wr_valid(wr_valid),
    .wr_ready(wr_ready3), .wr_idx(wr_idx), .wr_data(wr_data), .frame_sync(frame_sync),
    .out_view(out_view3), .out_objs(out_objs3), .wr_err(wr_err3));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int mx, my, mh;
  logic [OBJ_W-1:0] mpend [NUM_OBJ];
  logic [OBJ_W-1:0] mlive [NUM_OBJ];
  logic [VIEW_W-1:0] mlive_view;
  bit merr3;
  logic [1:0] rprev, mprev;
  int rhold, mhold;

  function automatic int nrm_x(int h);
    return int'(16.0 * $sin(real'(h) * 3.14159265358979 / 8.0));
  endfunction
  function automatic int nrm_y(int h);
    return int'(16.0 * $cos(real'(h) * 3.14159265358979 / 8.0));
  endfunction
  function automatic logic [VIEW_W-1:0] view_of(int h, int x, int y);
    logic [10:0] nx, ny;
    nx = 11'(nrm_x(h));
    ny = 11'(nrm_y(h));
    return {4'(h), nx, ny, X_W'(x), Y_W'(y), Z_W'(0)};
  endfunction
  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mh = 0; merr3 = 0;
    rprev = 0; mprev = 0; rhold = 0; mhold = 0;
    mpend[0] = {1'b1, 1'b0, 12'hFFF, X_W'(0), X_W'(16), Y_W'(32), Y_W'(0), Z_W'(16), Z_W'(0)};
    mpend[1] = {1'b1, 1'b1, 12'hFFF, X_W'(16), X_W'(32), Y_W'(20), Y_W'(36), Z_W'(0), Z_W'(30)};
    for (int i = 2; i < NUM_OBJ; i++) mpend[i] = '0;
    for (int i = 0; i < NUM_OBJ; i++) mlive[i] = mpend[i];
    mlive_view = view_of(0, 0, 0);
  endtask

  task automatic fire_calc(input logic [1:0] code, inout logic [1:0] prev, inout int hold,
                           output bit f);
    if (code == prev) hold++;
    else hold = 0;
    f = (code == 2'b01 || code == 2'b10) && (hold % REPEAT == 0);
    prev = code;
  endtask

  task automatic model_edge();
    bit rf, mf;
    int dir, dx, dy;
    fire_calc(rotate, rprev, rhold, rf);
    fire_calc(move, mprev, mhold, mf);
    if (frame_sync) begin
      mlive_view = view_of(mh, mx, my);
      for (int i = 0; i < NUM_OBJ; i++) mlive[i] = mpend[i];
    end
    if (mf) begin
      dir = (move == 2'b10) ? 1 : -1;
      dx = int'($floor(real'(nrm_x(mh)) / real'(1 << STEP_SHIFT)));
      dy = int'($floor(real'(nrm_y(mh)) / real'(1 << STEP_SHIFT)));
      mx = clampi(mx + dir * dx, (1 << X_W) - 1);
      my = clampi(my + dir * dy, (1 << Y_W) - 1);
    end
    if (rf) mh = (mh + ((rotate == 2'b01) ? 1 : 15)) % 16;
    if (wr_valid && !frame_sync) begin
      if (wr_idx < NUM_OBJ) mpend[wr_idx] = wr_data;
      if (wr_idx >= 3) merr3 = 1;
    end
  endtask

  // ---------------- driver / checker ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_OBJ*OBJ_W-1:0] eo;
    for (int i = 0; i < NUM_OBJ; i++) eo[i*OBJ_W +: OBJ_W] = mlive[i];
    check({tag, ".view"}, out_view, mlive_view);
    check({tag, ".objs"}, out_objs, eo);
    check({tag, ".objs3"}, out_objs3, eo[3*OBJ_W-1:0]);
    check({tag, ".view3"}, out_view3, mlive_view);
    check({tag, ".err"}, {wr_err3, wr_err}, {merr3, 1'b0});
    check({tag, ".ready"}, {wr_ready3, wr_ready}, {2{~frame_sync}});
  endtask

  task automatic commit();
    frame_sync = 1; tick(); frame_sync = 0; tick();
  endtask

  task automatic pulse_rot(input logic [1:0] c);
    rotate = c; tick(); rotate = 0; tick();
  endtask

  task automatic pulse_mv(input logic [1:0] c);
    move = c; tick(); move = 0; tick();
  endtask

  function automatic logic [OBJ_W-1:0] rnd_obj();
    return OBJ_W'({$urandom, $urandom, $urandom});
  endfunction

  logic [OBJ_W-1:0] wd;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    rst = 1;
    tick();
    commit();
    check_all("reset_commit");
    check("reset_view_const", out_view, {4'd0, 11'd0, 11'd16, 28'd0});

    // hold forward 2*REPEAT+1 cycles: three actions of +4 in y
    move = 2'b10;
    repeat (2 * REPEAT + 1) tick();
    move = 0; tick();
    commit();
    check_all("hold_fwd");
    check("hold_fwd_y", out_view[Z_W +: Y_W], 10'd12);

    for (int i = 0; i < 4; i++) pulse_mv(2'b01);
    commit();
    check_all("back_sat");
    check("back_sat_y", out_view[Z_W +: Y_W], 10'd0);

    pulse_rot(2'b01);
    commit();
    check("rot_h1", out_view[VIEW_W-1 -: 4], 4'd1);
    for (int i = 0; i < 16; i++) pulse_rot(2'b01);
    commit();
    check_all("rot_wrap");
    check("rot_wrap_h", out_view[VIEW_W-1 -: 4], 4'd1);

    pulse_rot(2'b01);
    pulse_mv(2'b10);
    commit();
    check_all("h2_fwd");

    // pending write is invisible until commit
    wd = rnd_obj(); wd[OBJ_W-1 -: 2] = 2'b10;
    wr_valid = 1; wr_idx = 2; wr_data = wd; tick(); wr_valid = 0; tick();
    check_all("wr_pending");
    commit();
    check_all("wr_commit");
    check("wr_slot2", out_objs[2*OBJ_W +: OBJ_W], wd);

    // write colliding with frame_sync is held off one cycle
    wd = rnd_obj();
    wr_valid = 1; wr_idx = 1; wr_data = wd; frame_sync = 1; #1;
    check("collide_ready", wr_ready, 1'b0);
    tick();
    frame_sync = 0; tick(); wr_valid = 0;
    commit();
    check_all("collide");
    check("collide_slot1", out_objs[OBJ_W +: OBJ_W], wd);

    wr_valid = 1; wr_idx = 3; wr_data = rnd_obj(); tick(); wr_valid = 0;
    commit();
    check_all("oob_write");
    check("oob_err3", wr_err3, 1'b1);

    pulse_rot(2'b10); pulse_rot(2'b10);
    rotate = 2'b01; move = 2'b10; tick(); rotate = 0; move = 0; tick();
    commit();
    check_all("rot_and_move");

    // randomized phase
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      rotate = 2'($urandom_range(0, 3));
      move = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_idx = 2'($urandom_range(0, 3));
        wr_data = rnd_obj();
        frame_sync = ($urandom_range(0, 7) == 0);
        tick();
        if (frame_sync) check_all("rand");
      end
    end
    wr_valid = 0; frame_sync = 0; rotate = 0; move = 0; tick();
    commit(); commit();
    check_all("double_commit");

    // asynchronous reset mid-hold
    move = 2'b10;
    repeat (5) tick();
    #2 rst = 0; #1;
    model_reset();
    check_all("mid_reset");
    #1 rst = 1;
    tick();
    move = 0;
    commit();
    check_all("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
